// File: rtl/feature_stream_unpacker.sv
// rtl/feature_stream_unpacker.sv - splits wide upstream beats into feature address words
// Holding register keeps one beat; the output register presents one lane at a time.
module feature_stream_unpacker #(
    parameter int IN_WIDTH    = 64,
    parameter int WORD_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] total_words,
    input  logic                   abort,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_WIDTH-1:0]  data,
    output logic                   data_ready,
    input  logic                   data_wanted,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_sent
);
    localparam int LANES  = IN_WIDTH / WORD_WIDTH;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IN_WIDTH-1:0]    hold_data;
    logic                   hold_valid;
    logic [LANE_W-1:0]      lane_idx;
    logic [COUNT_WIDTH-1:0] words_left;
    logic [WORD_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic [WORD_WIDTH-1:0]  lane_words [LANES];

    logic abort_now;
    logic out_free;
    logic out_xfer;
    logic lane_move;
    logic lane_wrap;
    logic last_move;
    logic in_xfer;

    for (genvar g = 0; g < LANES; g++) begin : g_lanes
        assign lane_words[g] = hold_data[g*WORD_WIDTH +: WORD_WIDTH];
    end

    assign abort_now = abort && (state != ST_IDLE);
    assign out_free  = !out_valid || data_wanted;
    assign out_xfer  = out_valid && data_wanted;
    assign lane_move = hold_valid && out_free;
    assign lane_wrap = (lane_idx == LANE_W'(LANES - 1));
    assign last_move = lane_move && (words_left == COUNT_WIDTH'(1));
    assign in_xfer   = in_ready && in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort_now) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = (total_words == '0) ? ST_DONE : ST_RUN;
                ST_RUN:   if (last_move) state_next = ST_DRAIN;
                ST_DRAIN: if (out_free) state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // A new beat is only taken when the current one is fully used and more words remain.
    always_comb begin
        in_ready   = (state == ST_RUN) && !abort &&
                     (!hold_valid || (lane_move && lane_wrap && !last_move));
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        data_ready = out_valid;
        data       = out_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            lane_idx   <= '0;
            words_left <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            words_sent <= '0;
        end else begin
            if (out_xfer) begin
                words_sent <= words_sent + COUNT_WIDTH'(1);
            end
            if (abort_now) begin
                hold_valid <= 1'b0;
                out_valid  <= 1'b0;
                out_data   <= '0;
                words_left <= '0;
            end else begin
                if (state == ST_IDLE && start) begin
                    words_left <= total_words;
                    words_sent <= '0;
                end
                if (lane_move) begin
                    out_data   <= lane_words[lane_idx];
                    out_valid  <= 1'b1;
                    lane_idx   <= lane_idx + LANE_W'(1);
                    words_left <= words_left - COUNT_WIDTH'(1);
                    if (lane_wrap || last_move) begin
                        hold_valid <= 1'b0;
                    end
                end else if (out_xfer) begin
                    out_valid <= 1'b0;
                end
                // A beat arriving together with the last lane move refills the holding register.
                if (in_xfer) begin
                    hold_data  <= in_data;
                    hold_valid <= 1'b1;
                    lane_idx   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_feature_stream_unpacker.sv
// tb/tb_feature_stream_unpacker.sv - directed bench with a lane-flattening reference model
module tb_feature_stream_unpacker;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] total_words;
    logic        abort;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data;
    logic        data_ready;
    logic        data_wanted;
    logic        busy;
    logic        done;
    logic [15:0] words_sent;

    feature_stream_unpacker #(.IN_WIDTH(64), .WORD_WIDTH(16), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .total_words(total_words), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .data_ready(data_ready), .data_wanted(data_wanted),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [63:0] beat_q[$];
    logic [15:0] exp_q[$];
    logic [31:0] dw_pat;
    int          pat_idx;
    int          done_cnt, done_cyc, xfer_cnt, fire_cnt, fire_cyc, ir_hi, start_cyc, taken;
    logic [15:0] got [0:63];
    int          xfer_cyc [0:63];
    bit          stall_valid = 0;
    bit          abort_prev = 0;
    logic [15:0] stall_data;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Compare process: every downstream transfer against the model, plus stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stall_valid = 0;
        end else begin
            if (stall_valid && !abort_prev) begin
                check("stall_hold_valid", data_ready, 1);
                check("stall_hold_data", data, stall_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (data_ready && data_wanted) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_word actual=%0h required=none", data);
                end else begin
                    check("word", data, exp_q.pop_front());
                end
                if (xfer_cnt < 64) begin
                    got[xfer_cnt] = data;
                    xfer_cyc[xfer_cnt] = cyc;
                end
                xfer_cnt++;
            end
            stall_valid = data_ready && !data_wanted;
            stall_data = data;
        end
        abort_prev = abort;
    end

    task automatic tick();
        logic fire;
        @(negedge clk);
        fire = in_valid && in_ready;
        if (in_ready) ir_hi++;
        if (fire) begin
            if (fire_cnt == 0) fire_cyc = cyc;
            fire_cnt++;
        end
        @(posedge clk);
        #1;
        if (fire) void'(beat_q.pop_front());
        in_valid = (beat_q.size() > 0);
        in_data = in_valid ? beat_q[0] : 64'h0;
        data_wanted = dw_pat[pat_idx];
        pat_idx = (pat_idx + 1) % 32;
    endtask

    // Model: the expected stream is simply the beats flattened lane 0 first, cut at n words.
    task automatic begin_load(input int n, input logic [31:0] pat);
        logic [63:0] b;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i / 4 < beat_q.size()) begin
                b = beat_q[i / 4];
                exp_q.push_back(b[(i % 4) * 16 +: 16]);
            end
        end
        done_cnt = 0; xfer_cnt = 0; fire_cnt = 0; ir_hi = 0; fire_cyc = 0; done_cyc = 0;
        dw_pat = pat; pat_idx = 0;
        data_wanted = 1;
        in_valid = (beat_q.size() > 0);
        in_data = in_valid ? beat_q[0] : 64'h0;
        start = 1;
        total_words = 16'(n);
        start_cyc = cyc;
        tick();
        start = 0;
    endtask

    task automatic run_load(input int n, input logic [31:0] pat, output int beats_taken);
        begin_load(n, pat);
        for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
        tick();
        tick();
        check("model_drained", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
        check("words_sent", words_sent, n);
        check("idle_after", busy, 0);
        beats_taken = fire_cnt;
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; total_words = 0;
        in_data = 0; in_valid = 0; data_wanted = 0;
        dw_pat = '1; pat_idx = 0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_sent", words_sent, 0);
        reset = 0;
        tick();

        // Eight words, no stalls
        beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        run_load(8, '1, taken);
        check("s1_beats", taken, 2);
        check("s1_latency", xfer_cyc[0], fire_cyc + 2);
        check("s1_back_to_back", xfer_cyc[7] - xfer_cyc[0], 7);
        check("s1_first_word", got[0], 16'h0001);
        check("s1_fifth_word", got[4], 16'h0005);
        check("s1_last_word", got[7], 16'h0008);

        // Five words: second beat partly discarded, third beat never taken
        beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h000c_000b_000a_0009};
        run_load(5, '1, taken);
        check("s2_beats", taken, 2);
        check("s2_left_in_queue", beat_q.size(), 1);
        check("s2_last_word", got[4], 16'h0005);
        check("s2_word_count", xfer_cnt, 5);
        beat_q.delete();
        in_valid = 0;

        // Twelve words with downstream stalls
        beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h000c_000b_000a_0009};
        run_load(12, 32'hB2E6_9C5B, taken);
        check("s3_beats", taken, 3);
        check("s3_word_count", xfer_cnt, 12);
        check("s3_word9", got[8], 16'h0009);

        // Zero words
        beat_q = {64'h0004_0003_0002_0001};
        run_load(0, '1, taken);
        check("s4_done_latency", done_cyc, start_cyc + 1);
        check("s4_in_ready_never", ir_hi, 0);
        check("s4_beats", taken, 0);
        beat_q.delete();
        in_valid = 0;

        // Abort after three of eight words, then a clean reload
        beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        begin_load(8, '1);
        for (int k = 0; k < 50 && xfer_cnt < 3; k++) tick();
        abort = 1;
        data_wanted = 0;
        tick();
        abort = 0;
        check("s5_busy", busy, 0);
        check("s5_data_ready", data_ready, 0);
        check("s5_in_ready", in_ready, 0);
        check("s5_words_sent", words_sent, 3);
        exp_q.delete();
        beat_q.delete();
        in_valid = 0;
        tick();
        tick();
        tick();
        check("s5_no_done", done_cnt, 0);
        beat_q = {64'h0044_0033_0022_0011};
        run_load(3, '1, taken);
        check("s5_reload_first", got[0], 16'h0011);
        check("s5_reload_last", got[2], 16'h0033);
        beat_q.delete();
        in_valid = 0;

        // Reset while words are in flight
        beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        begin_load(8, '1);
        for (int k = 0; k < 20 && !data_ready; k++) tick();
        check("s6_pre_data_ready", data_ready, 1);
        reset = 1;
        tick();
        check("s6_in_ready", in_ready, 0);
        check("s6_data_ready", data_ready, 0);
        check("s6_data", data, 0);
        check("s6_busy", busy, 0);
        check("s6_done", done, 0);
        check("s6_words_sent", words_sent, 0);
        reset = 0;
        beat_q.delete();
        exp_q.delete();
        in_valid = 0;
        done_cnt = 0;
        tick();
        tick();
        tick();
        check("s6_no_done", done_cnt, 0);
        check("s6_still_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
